// File: rtl/uartreader_if.sv
// rtl/uartreader_if.sv - RX FIFO write-side handshake between uartreader and the RX FIFO
interface uartreader_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  fifo_full;
  logic                  fifo_write_en;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (
    input  fifo_full,
    output fifo_write_en,
    output fifo_data
  );

  modport slave (
    output fifo_full,
    input  fifo_write_en,
    input  fifo_data
  );
endinterface

// File: rtl/uartreader.sv
// rtl/uartreader.sv - oversampling UART receiver feeding the RX FIFO via a one-entry hold register (optional UARTREADER_PARITY_EN selects 8E1)
module uartreader #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          clear_status,
  output logic          frame_err,
  output logic          overrun,
  output logic          parity_err,
  output logic          busy,
  uartreader_if.master  fifo
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
  localparam logic [SCW-1:0] SC_MID    = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST   = SCW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UARTREADER_PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t         state, state_n;
  logic           rx_meta, rx_s;
  logic [TW-1:0]  tcnt;
  logic           tick;
  logic [SCW-1:0] sc, sc_n;
  logic [2:0]     bitcnt, bitcnt_n;
  logic [7:0]     shift, shift_n;
  logic           done, frame_set, par_set;
  logic           pending;
  logic [7:0]     hold;
  logic           wr;
  logic [DATA_WIDTH-1:0] data_ext;
`ifdef UARTREADER_PARITY_EN
  logic           par_bad, par_bad_n;
`endif

  // Two-flop synchronizer; idle-high so reset does not look like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (tcnt == TICK_LAST);

  // Free-running sample-tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      sc     <= '0;
      bitcnt <= '0;
      shift  <= '0;
`ifdef UARTREADER_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      sc     <= sc_n;
      bitcnt <= bitcnt_n;
      shift  <= shift_n;
`ifdef UARTREADER_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  // Frame sequencing: start qualification, mid-bit sampling, stop/break handling
  always_comb begin
    state_n   = state;
    sc_n      = sc;
    bitcnt_n  = bitcnt;
    shift_n   = shift;
    done      = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
`ifdef UARTREADER_PARITY_EN
    par_bad_n = par_bad;
`endif
    case (state)
      S_IDLE: begin
        if (tick && !rx_s) begin
          sc_n    = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (sc == SC_MID) begin
            if (rx_s) begin
              state_n = S_IDLE;
            end else begin
              sc_n     = '0;
              bitcnt_n = '0;
              state_n  = S_DATA;
            end
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (sc == SC_LAST) begin
            shift_n  = {rx_s, shift[7:1]};
            sc_n     = '0;
            bitcnt_n = bitcnt + 1'b1;
            if (bitcnt == 3'd7) begin
`ifdef UARTREADER_PARITY_EN
              state_n = S_PAR;
`else
              state_n = S_STOP;
`endif
            end
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
`ifdef UARTREADER_PARITY_EN
      S_PAR: begin
        if (tick) begin
          if (sc == SC_LAST) begin
            par_bad_n = (rx_s != (^shift));
            sc_n      = '0;
            state_n   = S_STOP;
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (sc == SC_LAST) begin
            sc_n = '0;
            if (rx_s) begin
`ifdef UARTREADER_PARITY_EN
              if (par_bad) par_set = 1'b1;
              else         done    = 1'b1;
`else
              done = 1'b1;
`endif
              state_n = S_IDLE;
            end else begin
              frame_set = 1'b1;
              state_n   = S_BREAK;
            end
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign wr   = pending & ~fifo.fifo_full;

  // Hold register: a byte arriving while the previous one drains still gets captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      hold    <= '0;
    end else if (done && (!pending || wr)) begin
      hold    <= shift;
      pending <= 1'b1;
    end else if (wr) begin
      pending <= 1'b0;
    end
  end

  // Sticky status bits; a same-cycle event beats clear_status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)          frame_err <= 1'b1;
      else if (clear_status)  frame_err <= 1'b0;
      if (done && pending && !wr) overrun <= 1'b1;
      else if (clear_status)      overrun <= 1'b0;
    end
  end

`ifdef UARTREADER_PARITY_EN
  // Sticky parity error
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               parity_err <= 1'b0;
    else if (par_set)      parity_err <= 1'b1;
    else if (clear_status) parity_err <= 1'b0;
  end
`else
  assign parity_err = par_set;
`endif

  // Zero-extend the held byte onto the FIFO data bus
  always_comb begin
    data_ext      = '0;
    data_ext[7:0] = hold;
  end

  assign fifo.fifo_write_en = wr;
  assign fifo.fifo_data     = data_ext;

endmodule

// File: tb/tb_uartreader.sv
// tb/tb_uartreader.sv - self-checking bench for uartreader at one clock per sample tick
`timescale 1ns/1ps
module tb_uartreader;
  localparam int DW = 16;
  localparam int BITCLK = 16;

  logic clk = 1'b0;
  logic rst, rx, clear_status;
  logic frame_err, overrun, parity_err, busy;

  uartreader_if #(.DATA_WIDTH(DW)) bus ();

  uartreader #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .clear_status(clear_status),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err),
    .busy(busy), .fifo(bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] got_q[$];
  logic [7:0]    exp_q[$];
  int   fe_rises = 0;
  logic fe_prev = 1'b0;
  logic busy_seen = 1'b0;

  // Monitor at the falling edge, midway between input changes and commits
  always @(negedge clk) begin
    if (bus.fifo_write_en) got_q.push_back(bus.fifo_data);
    if (frame_err && !fe_prev) fe_rises++;
    fe_prev = frame_err;
    if (busy) busy_seen = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    cyc(BITCLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UARTREADER_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    send_bit(stop);
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    cyc(1);
    clear_status = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; clear_status = 1'b0; bus.fifo_full = 1'b0;
    cyc(3);
    n_checks += 6;
    if (bus.fifo_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.fifo_write_en); end
    if (bus.fifo_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", bus.fifo_data); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    cyc(4);
  endtask

  task automatic test_basic(input int nbytes, input int gap);
    logic [7:0] b;
    got_q.delete(); exp_q.delete();
    for (int k = 0; k < nbytes; k++) begin
      b = (k == 0 && gap > 0) ? 8'hA5 : 8'($urandom);
      send_frame(b, ^b, 1'b1);
      exp_q.push_back(b);
      if (gap > 0) cyc(gap);
    end
    cyc(20);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_count(gap=%0d): got %0d writes expected %0d", gap, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== {8'h00, exp_q[i]}) begin
        n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_q[i], {8'h00, exp_q[i]});
      end
    end
    n_checks++;
    if ({frame_err, overrun, parity_err} !== 3'b000) begin
      n_fail++; $display("FAIL basic_status: got %b expected 000", {frame_err, overrun, parity_err});
    end
  endtask

  task automatic test_glitch();
    got_q.delete();
    busy_seen = 1'b0;
    rx = 1'b0;
    cyc(5);
    rx = 1'b1;
    cyc(40);
    n_checks += 4;
    if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_seen: got %b expected 1", busy_seen); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_idle: got %b expected 0", busy); end
    if (got_q.size() != 0) begin n_fail++; $display("FAIL glitch_writes: got %0d expected 0", got_q.size()); end
    if ({frame_err, overrun, parity_err} !== 3'b000) begin
      n_fail++; $display("FAIL glitch_status: got %b expected 000", {frame_err, overrun, parity_err});
    end
  endtask

  task automatic test_frame_err();
    got_q.delete();
    fe_rises = 0;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    cyc(20 * BITCLK);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b expected 1", busy); end
    cyc(20 * BITCLK);
    rx = 1'b1;
    cyc(32);
    send_frame(8'h11, ^8'h11, 1'b1);
    cyc(20);
    n_checks += 4;
    if (fe_rises != 1) begin n_fail++; $display("FAIL frame_err_events: got %0d expected 1", fe_rises); end
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_sticky: got %b expected 1", frame_err); end
    if (got_q.size() != 1) begin n_fail++; $display("FAIL frame_err_writes: got %0d expected 1", got_q.size()); end
    else if (got_q[0] !== 16'h0011) begin n_fail++; $display("FAIL frame_err_data: got %h expected 0011", got_q[0]); end
    pulse_clear();
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_err_clear: got %b expected 0", frame_err); end
  endtask

  task automatic test_overrun();
    logic [7:0] a, b;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 8'h01 : 8'($urandom);
      b = (k == 0) ? 8'h02 : 8'($urandom);
      got_q.delete();
      bus.fifo_full = 1'b1;
      send_frame(a, ^a, 1'b1);
      send_frame(b, ^b, 1'b1);
      cyc(20);
      n_checks += 2;
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set[%0d]: got %b expected 1", k, overrun); end
      if (got_q.size() != 0) begin n_fail++; $display("FAIL overrun_held[%0d]: got %0d writes expected 0", k, got_q.size()); end
      bus.fifo_full = 1'b0;
      cyc(6);
      n_checks++;
      if (got_q.size() != 1) begin n_fail++; $display("FAIL overrun_drain[%0d]: got %0d writes expected 1", k, got_q.size()); end
      else if (got_q[0] !== {8'h00, a}) begin
        n_fail++; $display("FAIL overrun_data[%0d]: got %h expected %h", k, got_q[0], {8'h00, a});
      end
      pulse_clear();
      n_checks++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear[%0d]: got %b expected 0", k, overrun); end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    rx = 1'b1;
    cyc(3);
    n_checks += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    if (bus.fifo_write_en !== 1'b0) begin n_fail++; $display("FAIL midreset_we: got %b expected 0", bus.fifo_write_en); end
    rst = 1'b0;
    cyc(10);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    cyc(20);
    n_checks++;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL midreset_writes: got %0d expected 1", got_q.size()); end
    else if (got_q[0] !== 16'h005A) begin n_fail++; $display("FAIL midreset_data: got %h expected 005a", got_q[0]); end
  endtask

  task automatic test_parity();
`ifdef UARTREADER_PARITY_EN
    logic [7:0] b;
    got_q.delete(); exp_q.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      send_frame(b, ^b, 1'b1);
      exp_q.push_back(b);
      b = 8'($urandom);
      send_frame(b, ~(^b), 1'b1);
    end
    cyc(20);
    n_checks += 3;
    if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_err_set: got %b expected 1", parity_err); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL parity_frame_err: got %b expected 0", frame_err); end
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL parity_writes: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== {8'h00, exp_q[i]}) begin
        n_fail++; $display("FAIL parity_data[%0d]: got %h expected %h", i, got_q[i], {8'h00, exp_q[i]});
      end
    end
    pulse_clear();
    n_checks++;
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_clear: got %b expected 0", parity_err); end
`else
    n_checks++;
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_tied: got %b expected 0", parity_err); end
`endif
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic(6, 8);
    test_glitch();
    test_basic(8, 0);
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
